// File: rtl/iv_bus_master.sv
// iv_bus_master: sequencing initiator for the 8X300-style IV bus.
// Takes single read/write requests over a valid/ready handshake and turns
// each into an address-select cycle (IO_SC) followed by either a write
// cycle (IO_WC) or a read window of READ_LAT cycles on n_xB_r.
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high; the requester holds req_valid (and its payload)
// until then. rsp_valid is a single-cycle pulse with no back-pressure.
//
// Optional feature: define IV_ADDR_CACHE_EN to keep the last selected
// address per bank and skip the SEL cycle on a repeat select; this adds
// the cache_flush input.
module iv_bus_master #(
  parameter int READ_LAT = 1
) (
  input  logic       clk,
  input  logic       n_reset,
`ifdef IV_ADDR_CACHE_EN
  input  logic       cache_flush,
`endif
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic       req_bank,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic [7:0] n_IV_out,
  input  logic [7:0] n_IV_in,
  output logic       IO_SC,
  output logic       IO_WC,
  output logic       IO_n_LB_w,
  output logic       IO_n_RB_w,
  output logic       IO_n_LB_r,
  output logic       IO_n_RB_r
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_e;

  // Last read-window cycle index; READ_LAT is limited to 1..4.
  localparam logic [1:0] CNT_LAST = 2'(READ_LAT - 1);

  state_e     state_q, state_d;
  logic       we_q, we_d;
  logic       bank_q, bank_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [1:0] cnt_q, cnt_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       sel_hit;

`ifdef IV_ADDR_CACHE_EN
  logic [1:0] cv_q, cv_d;
  logic [7:0] ca0_q, ca0_d;
  logic [7:0] ca1_q, ca1_d;

  // A flush in the accept cycle forces a full select.
  always_comb begin
    sel_hit = 1'b0;
    if (!cache_flush) begin
      if (req_bank) sel_hit = cv_q[1] && (ca1_q == req_addr);
      else          sel_hit = cv_q[0] && (ca0_q == req_addr);
    end
  end
`else
  assign sel_hit = 1'b0;
`endif

  // Ready only when idle and out of reset; no dependence on req_valid.
  assign req_ready = (state_q == ST_IDLE) && n_reset;
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  // State register and captured request; async reset drops any transfer.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      bank_q      <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      cnt_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
`ifdef IV_ADDR_CACHE_EN
      cv_q        <= 2'b00;
      ca0_q       <= 8'h00;
      ca1_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      bank_q      <= bank_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef IV_ADDR_CACHE_EN
      cv_q        <= cv_d;
      ca0_q       <= ca0_d;
      ca1_q       <= ca1_d;
`endif
    end
  end

  // Next-state, request capture, read counter and response capture.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    bank_d      = bank_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef IV_ADDR_CACHE_EN
    cv_d        = cv_q;
    ca0_d       = ca0_q;
    ca1_d       = ca1_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          bank_d  = req_bank;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 2'd0;
          if (sel_hit) state_d = req_we ? ST_WR : ST_RD;
          else         state_d = ST_SEL;
        end
      end
      ST_SEL: begin
        state_d = we_q ? ST_WR : ST_RD;
`ifdef IV_ADDR_CACHE_EN
        if (bank_q) begin
          ca1_d    = addr_q;
          cv_d[1]  = 1'b1;
        end else begin
          ca0_d    = addr_q;
          cv_d[0]  = 1'b1;
        end
`endif
      end
      ST_WR: begin
        state_d = ST_IDLE;
      end
      ST_RD: begin
        if (cnt_q == CNT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ~n_IV_in;
          cnt_d       = 2'd0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef IV_ADDR_CACHE_EN
    if (cache_flush) cv_d = 2'b00;
`endif
  end

  // Bus drive decoded from state; only the captured bank's strobes move.
  always_comb begin
    IO_SC     = 1'b0;
    IO_WC     = 1'b0;
    IO_n_LB_w = 1'b1;
    IO_n_RB_w = 1'b1;
    IO_n_LB_r = 1'b1;
    IO_n_RB_r = 1'b1;
    n_IV_out  = 8'hFF;
    case (state_q)
      ST_SEL: begin
        IO_SC     = 1'b1;
        IO_n_LB_w = bank_q;
        IO_n_RB_w = ~bank_q;
        n_IV_out  = ~addr_q;
      end
      ST_WR: begin
        IO_WC     = 1'b1;
        IO_n_LB_w = bank_q;
        IO_n_RB_w = ~bank_q;
        n_IV_out  = ~wdata_q;
      end
      ST_RD: begin
        IO_n_LB_r = bank_q;
        IO_n_RB_r = ~bank_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iv_bus_master.sv
// Directed bench for iv_bus_master. DUT a (READ_LAT=1) talks to a small
// two-bank testmem; DUTs b (READ_LAT=4) and c (READ_LAT=3) share one
// request bus and a directly driven n_IV_in for the reset-abort and
// long-latency reads. Build with +define+IV_ADDR_CACHE_EN for the cache test.
module tb_iv_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUT a ----------------
  logic       n_reset_a, valid_a, we_a, bank_a, flush_a;
  logic [7:0] addr_a, wdata_a, n_iv_in_a;
  logic       ready_a, rv_a, busy_a, sc_a, wc_a, lbw_a, rbw_a, lbr_a, rbr_a;
  logic [7:0] rdata_a, n_iv_out_a;

  iv_bus_master #(.READ_LAT(1)) u_dut_a (
    .clk(clk), .n_reset(n_reset_a),
`ifdef IV_ADDR_CACHE_EN
    .cache_flush(flush_a),
`endif
    .req_valid(valid_a), .req_ready(ready_a), .req_we(we_a), .req_bank(bank_a),
    .req_addr(addr_a), .req_wdata(wdata_a), .rsp_valid(rv_a), .rsp_rdata(rdata_a),
    .busy(busy_a), .n_IV_out(n_iv_out_a), .n_IV_in(n_iv_in_a), .IO_SC(sc_a),
    .IO_WC(wc_a), .IO_n_LB_w(lbw_a), .IO_n_RB_w(rbw_a), .IO_n_LB_r(lbr_a),
    .IO_n_RB_r(rbr_a)
  );

  // Two-bank testmem: latches the selected address on SC, writes on WC.
  logic [7:0] mem_l [256];
  logic [7:0] mem_r [256];
  logic [7:0] sel_l = 8'h00;
  logic [7:0] sel_r = 8'h00;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_l[i] = 8'h00;
      mem_r[i] = 8'h00;
    end
  end

  always @(posedge clk) begin
    if (sc_a && !lbw_a) sel_l <= ~n_iv_out_a;
    if (sc_a && !rbw_a) sel_r <= ~n_iv_out_a;
    if (wc_a && !lbw_a) mem_l[sel_l] <= ~n_iv_out_a;
    if (wc_a && !rbw_a) mem_r[sel_r] <= ~n_iv_out_a;
  end

  assign n_iv_in_a = !lbr_a ? ~mem_l[sel_l] : (!rbr_a ? ~mem_r[sel_r] : 8'hFF);

  int rsp_cnt_a = 0;
  always @(negedge clk) if (rv_a) rsp_cnt_a <= rsp_cnt_a + 1;

  // ---------------- DUTs b and c ----------------
  logic       n_reset_b, valid_b, we_b, bank_b, flush_b;
  logic [7:0] addr_b, wdata_b, n_iv_in_b;
  logic       ready_b, rv_b, busy_b, sc_b, wc_b, lbw_b, rbw_b, lbr_b, rbr_b;
  logic [7:0] rdata_b, n_iv_out_b;
  logic       ready_c, rv_c, busy_c, sc_c, wc_c, lbw_c, rbw_c, lbr_c, rbr_c;
  logic [7:0] rdata_c, n_iv_out_c;

  iv_bus_master #(.READ_LAT(4)) u_dut_b (
    .clk(clk), .n_reset(n_reset_b),
`ifdef IV_ADDR_CACHE_EN
    .cache_flush(flush_b),
`endif
    .req_valid(valid_b), .req_ready(ready_b), .req_we(we_b), .req_bank(bank_b),
    .req_addr(addr_b), .req_wdata(wdata_b), .rsp_valid(rv_b), .rsp_rdata(rdata_b),
    .busy(busy_b), .n_IV_out(n_iv_out_b), .n_IV_in(n_iv_in_b), .IO_SC(sc_b),
    .IO_WC(wc_b), .IO_n_LB_w(lbw_b), .IO_n_RB_w(rbw_b), .IO_n_LB_r(lbr_b),
    .IO_n_RB_r(rbr_b)
  );

  iv_bus_master #(.READ_LAT(3)) u_dut_c (
    .clk(clk), .n_reset(n_reset_b),
`ifdef IV_ADDR_CACHE_EN
    .cache_flush(flush_b),
`endif
    .req_valid(valid_b), .req_ready(ready_c), .req_we(we_b), .req_bank(bank_b),
    .req_addr(addr_b), .req_wdata(wdata_b), .rsp_valid(rv_c), .rsp_rdata(rdata_c),
    .busy(busy_c), .n_IV_out(n_iv_out_c), .n_IV_in(n_iv_in_b), .IO_SC(sc_c),
    .IO_WC(wc_c), .IO_n_LB_w(lbw_c), .IO_n_RB_w(rbw_c), .IO_n_LB_r(lbr_c),
    .IO_n_RB_r(rbr_c)
  );

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_a(input logic we, input logic bank, input logic [7:0] addr,
                       input logic [7:0] wdata);
    valid_a = 1'b1; we_a = we; bank_a = bank; addr_a = addr; wdata_a = wdata;
  endtask

  task automatic req_b(input logic we, input logic bank, input logic [7:0] addr);
    valid_b = 1'b1; we_b = we; bank_b = bank; addr_b = addr; wdata_b = 8'h00;
  endtask

  int cnt_before;

  initial begin
    n_reset_a = 1'b0; n_reset_b = 1'b0;
    valid_a = 1'b0; we_a = 1'b0; bank_a = 1'b0; addr_a = 8'h00; wdata_a = 8'h00;
    valid_b = 1'b0; we_b = 1'b0; bank_b = 1'b0; addr_b = 8'h00; wdata_b = 8'h00;
    n_iv_in_b = 8'hFF;
    // While set, every accept coincides with a flush and so performs SEL.
`ifdef IV_ADDR_CACHE_EN
    flush_a = 1'b1; flush_b = 1'b1;
`else
    flush_a = 1'b0; flush_b = 1'b0;
`endif
    tick(); tick();

    // Reset values
    check("rst_ready", {15'd0, ready_a}, 16'd0);
    check("rst_sc_wc", {14'd0, sc_a, wc_a}, 16'd0);
    check("rst_strobes", {12'd0, lbw_a, rbw_a, lbr_a, rbr_a}, 16'hF);
    check("rst_niv", {8'd0, n_iv_out_a}, 16'h00FF);
    check("rst_rsp", {7'd0, rv_a, rdata_a}, 16'h0000);
    check("rst_busy", {15'd0, busy_a}, 16'd0);
    n_reset_a = 1'b1; n_reset_b = 1'b1;
    #1;
    check("rel_ready", {15'd0, ready_a}, 16'd1);

    // 1: write LB 12 <= A5
    req_a(1'b1, 1'b0, 8'h12, 8'hA5);
    tick();
    valid_a = 1'b0;
    check("w1_sel_sc", {14'd0, sc_a, wc_a}, 16'b10);
    check("w1_sel_strb", {12'd0, lbw_a, rbw_a, lbr_a, rbr_a}, 16'b0111);
    check("w1_sel_niv", {8'd0, n_iv_out_a}, 16'h00ED);
    check("w1_sel_busy", {14'd0, busy_a, ready_a}, 16'b10);
    tick();
    check("w1_wr_wc", {14'd0, sc_a, wc_a}, 16'b01);
    check("w1_wr_strb", {12'd0, lbw_a, rbw_a, lbr_a, rbr_a}, 16'b0111);
    check("w1_wr_niv", {8'd0, n_iv_out_a}, 16'h005A);
    tick();
    check("w1_idle", {13'd0, ready_a, busy_a, wc_a}, 16'b100);
    check("w1_idle_niv", {8'd0, n_iv_out_a}, 16'h00FF);
    check("w1_mem", {8'd0, mem_l[8'h12]}, 16'h00A5);

    // 2: read LB 12, READ_LAT=1
    req_a(1'b0, 1'b0, 8'h12, 8'h00);
    tick();
    valid_a = 1'b0;
    check("r2_sel", {6'd0, sc_a, wc_a, n_iv_out_a}, 16'h02ED);
    check("r2_sel_strb", {12'd0, lbw_a, rbw_a, lbr_a, rbr_a}, 16'b0111);
    tick();
    check("r2_rd_strb", {12'd0, lbw_a, rbw_a, lbr_a, rbr_a}, 16'b1101);
    check("r2_rd_bus", {6'd0, sc_a, wc_a, n_iv_out_a}, 16'h00FF);
    check("r2_rd_rv", {15'd0, rv_a}, 16'd0);
    tick();
    check("r2_rsp", {7'd0, rv_a, rdata_a}, 16'h01A5);
    check("r2_idle_strb", {12'd0, lbw_a, rbw_a, lbr_a, rbr_a}, 16'hF);
    tick();
    check("r2_rsp_end", {7'd0, rv_a, rdata_a}, 16'h00A5);

    // 3: back-to-back write 01 <= 3C, read 01, then read 12 in the rsp cycle
    req_a(1'b1, 1'b0, 8'h01, 8'h3C);
    tick();
    check("b3_w_sel", {6'd0, sc_a, wc_a, n_iv_out_a}, 16'h02FE);
    tick();
    req_a(1'b0, 1'b0, 8'h01, 8'h00);
    check("b3_w_wr", {6'd0, sc_a, wc_a, n_iv_out_a}, 16'h01C3);
    tick();
    check("b3_idle_ready", {15'd0, ready_a}, 16'd1);
    cnt_before = rsp_cnt_a;
    tick();
    check("b3_r_sel", {6'd0, sc_a, wc_a, n_iv_out_a}, 16'h02FE);
    tick();
    req_a(1'b0, 1'b0, 8'h12, 8'h00);
    check("b3_r_rd", {15'd0, lbr_a}, 16'd0);
    tick();
    check("b3_rsp", {7'd0, rv_a, rdata_a}, 16'h013C);
    check("b3_rsp_ready", {15'd0, ready_a}, 16'd1);
    tick();
    valid_a = 1'b0;
    check("b3_next_sel", {6'd0, sc_a, wc_a, n_iv_out_a}, 16'h02ED);
    check("b3_one_pulse", 16'(rsp_cnt_a - cnt_before), 16'd1);
    tick();
    tick();
    check("b3_rsp2", {7'd0, rv_a, rdata_a}, 16'h01A5);

`ifdef IV_ADDR_CACHE_EN
    // 5: address cache on RB 40
    flush_a = 1'b0;
    tick();
    req_a(1'b1, 1'b1, 8'h40, 8'h11);
    tick();
    valid_a = 1'b0;
    check("c5_w1_sel", {14'd0, sc_a, rbw_a}, 16'b10);
    tick();
    tick();
    req_a(1'b1, 1'b1, 8'h40, 8'h22);
    tick();
    valid_a = 1'b0;
    check("c5_w2_nosel", {6'd0, sc_a, wc_a, n_iv_out_a}, 16'h01DD);
    check("c5_w2_strb", {14'd0, lbw_a, rbw_a}, 16'b10);
    tick();
    check("c5_w2_idle", {14'd0, ready_a, busy_a}, 16'b10);
    check("c5_w2_mem", {8'd0, mem_r[8'h40]}, 16'h0022);
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    req_a(1'b1, 1'b1, 8'h40, 8'h33);
    tick();
    valid_a = 1'b0;
    check("c5_w3_sel", {6'd0, sc_a, wc_a, n_iv_out_a}, 16'h02BF);
    tick();
    tick();
    check("c5_w3_mem", {8'd0, mem_r[8'h40]}, 16'h0033);
`endif

    // 4: reset during RD at counter=2 (b: READ_LAT=4, c: READ_LAT=3)
    req_b(1'b0, 1'b1, 8'h77);
    tick();
    valid_b = 1'b0;
    check("r4_sel", {6'd0, sc_b, rbw_b, n_iv_out_b}, 16'h0288);
    tick();
    tick();
    tick();
    check("r4_rd_cnt2", {14'd0, rbr_b, lbr_b}, 16'b01);
    #2;
    n_reset_b = 1'b0;
    #1;
    check("r4_async_strb", {12'd0, lbw_b, rbw_b, lbr_b, rbr_b}, 16'hF);
    check("r4_async_ctl", {12'd0, sc_b, wc_b, busy_b, ready_b}, 16'd0);
    check("r4_async_niv", {8'd0, n_iv_out_b}, 16'h00FF);
    tick();
    check("r4_no_rsp", {14'd0, rv_b, rv_c}, 16'd0);
    n_reset_b = 1'b1;
    n_iv_in_b = 8'h96;
    req_b(1'b0, 1'b0, 8'h05);
    tick();
    valid_b = 1'b0;
    check("r4_again_sel", {6'd0, sc_b, lbw_b, n_iv_out_b}, 16'h02FA);
    tick(); tick(); tick();
    tick();
    check("r4_c_rsp", {7'd0, rv_c, rdata_c}, 16'h0169);
    check("r4_b_still_rd", {14'd0, rv_b, lbr_b}, 16'd0);
    tick();
    check("r4_b_rsp", {7'd0, rv_b, rdata_b}, 16'h0169);
    check("r4_c_rsp_end", {15'd0, rv_c}, 16'd0);
    tick();

    // 6: READ_LAT=3 read of a zero location (n_IV_in = FF)
    n_iv_in_b = 8'hFF;
    req_b(1'b0, 1'b0, 8'h20);
    tick();
    valid_b = 1'b0;
    check("r6_sel", {14'd0, sc_c, lbr_c}, 16'b11);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("r6_strobe_low", {13'd0, sc_c, lbr_c, rv_c}, 16'd0);
    end
    tick();
    check("r6_rsp", {6'd0, lbr_c, rv_c, rdata_c}, 16'h0300);
    tick();
    check("r6_b_rsp", {7'd0, rv_b, rdata_b}, 16'h0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
